// File: rtl/bus_ram_pkg.sv
// Shared sizing helpers and parameter sanity checks for bus_ram.
// Imported by the top and the storage array.
package bus_ram_pkg;

   function automatic int bytes_per_word(input int dw);
      return dw / 8;
   endfunction

   function automatic int off_width(input int dw);
      return $clog2(dw / 8);
   endfunction

   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic bit cfg_ok(input int dw, input int depth, input int lat);
      return (dw > 0) && (dw % 8 == 0) && (depth > 0) &&
             ((depth & (depth - 1)) == 0) && (lat == 1 || lat == 2);
   endfunction

endpackage

// File: rtl/bus_ram_ram_array.sv
// Byte-enabled single-port synchronous RAM, read-before-write.
// Holds only storage and its read register so it maps onto a BRAM.
module ram_array
   import bus_ram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2048,
   parameter int IDXW       = 11
) (
   input  logic                    clk,
   input  logic                    en_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [IDXW-1:0]         idx_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   output logic [DATA_WIDTH-1:0]   rdata_o
);

   localparam int BPW = bytes_per_word(DATA_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en_i) begin
         rdata_q <= mem_q[idx_i];
         for (int i = 0; i < BPW; i++) begin
            if (be_i[i]) begin
               mem_q[idx_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_ram.sv
// Word-addressed data memory with byte enables, range fault and a
// valid/ready request/response pipeline of latency 1 or 2.
module bus_ram
   import bus_ram_pkg::*;
#(
   parameter int                  DATA_WIDTH   = 32,
   parameter int                  DEPTH        = 2048,
   parameter int                  ADDR_WIDTH   = 32,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter int                  READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH/8-1:0] req_write_mask,
   input  logic [DATA_WIDTH-1:0]   req_write_value,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [DATA_WIDTH-1:0]   resp_read_value,
   output logic                    resp_fault
);

   localparam int OFFW = off_width(DATA_WIDTH);
   localparam int IDXW = idx_width(DEPTH);
   localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH+1)'(DEPTH);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] read_value;
      logic                  fault;
   } resp_t;

   if (!cfg_ok(DATA_WIDTH, DEPTH, READ_LATENCY)) begin : g_cfg_err
      $error("bus_ram: illegal parameter combination");
   end

   logic [ADDR_WIDTH-1:0] offset;
   logic [ADDR_WIDTH-1:0] word_off;
   logic [IDXW-1:0]       index;
   logic                  fault;
   logic                  advance;
   logic                  accept;
   logic                  ram_en;
   logic [DATA_WIDTH-1:0] ram_rdata;

   logic s1_valid_q, s1_valid_d;
   logic s1_fault_q, s1_fault_d;

   assign offset   = req_addr - BASE_ADDR;
   assign word_off = offset >> OFFW;
   assign index    = word_off[IDXW-1:0];
   assign fault    = (req_addr < BASE_ADDR) ||
                     ({1'b0, word_off} >= DEPTH_A);

   assign advance   = !resp_valid || resp_ready;
   assign req_ready = advance;
   assign accept    = req_valid && advance;
   // Gated by reset so a request held during reset never writes.
   assign ram_en    = accept && !fault && reset_n;

   ram_array #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH),
      .IDXW      (IDXW)
   ) u_array (
      .clk    (clk),
      .en_i   (ram_en),
      .be_i   (req_write_mask),
      .idx_i  (index),
      .wdata_i(req_write_value),
      .rdata_o(ram_rdata)
   );

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_fault_d = s1_fault_q;
      if (advance) begin
         s1_valid_d = req_valid;
         s1_fault_d = req_valid && fault;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_fault_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_fault_q <= s1_fault_d;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic  resp_valid_q, resp_valid_d;
      resp_t resp_q, resp_d;

      always_comb begin
         resp_valid_d = resp_valid_q;
         resp_d       = resp_q;
         if (advance) begin
            resp_valid_d      = s1_valid_q;
            resp_d.fault      = s1_valid_q && s1_fault_q;
            resp_d.read_value = (s1_valid_q && !s1_fault_q) ?
                                ram_rdata : '0;
         end
      end

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
         end else begin
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
         end
      end

      assign resp_valid      = resp_valid_q;
      assign resp_read_value = resp_q.read_value;
      assign resp_fault      = resp_q.fault;
   end else begin : g_lat1
      // The array read register is the response data register.
      assign resp_valid      = s1_valid_q;
      assign resp_fault      = s1_fault_q;
      assign resp_read_value = (s1_valid_q && !s1_fault_q) ?
                               ram_rdata : '0;
   end

endmodule
